// File: rtl/gdp.sv
// gdp: generic deparser closing the ingress parse path.
//
// Inputs are the finished metadata (MD) and header vector (PHV) from the last
// pipeline stage, and the original packet beats replayed from the data cache.
// The packet is re-emitted with beat 0 replaced by MD, which carries this
// block's LMID stamped into MD[95:88]. Beats 1..3 are replaced by PHV segments
// PHV[767:512], PHV[511:256] and PHV[255:0]. Beats 4 and later pass through
// unchanged. A packet whose MD[127] is set is consumed silently and counted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_gdp_md[_wr]        metadata and its write strobe
//   out_gdp_md_alf        MD holding register occupied
//   in_gdp_phv[_wr]       header vector and its write strobe
//   out_gdp_phv_alf       PHV holding register occupied
//   in_gdp_data*, in_gdp_axis_*   cached packet beats (tuser 01 head, 00 body, 10 tail)
//   out_gdp_data_ready    beat accepted when valid & ready
//   pktout_*              registered output beat, 1-cycle latency from accept
//   in_pktout_alf         downstream almost-full, removes ready in the same cycle
//   gdp_drop_count        packets dropped via MD[127], saturating
//   gdp_err_count         MD/PHV writes lost to a full holding register, saturating
module gdp #(
  parameter string      PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [255:0]  in_gdp_md,
  input  logic          in_gdp_md_wr,
  output logic          out_gdp_md_alf,
  input  logic [1023:0] in_gdp_phv,
  input  logic          in_gdp_phv_wr,
  output logic          out_gdp_phv_alf,
  input  logic [255:0]  in_gdp_data,
  input  logic          in_gdp_data_valid,
  input  logic [1:0]    in_gdp_axis_tuser,
  input  logic [31:0]   in_gdp_axis_tkeep,
  output logic          out_gdp_data_ready,
  output logic [255:0]  pktout_data,
  output logic          pktout_data_wr,
  output logic [1:0]    pktout_axis_tuser,
  output logic [31:0]   pktout_axis_tkeep,
  output logic          pktout_valid_wr,
  output logic          pktout_valid,
  input  logic          in_pktout_alf,
  output logic [31:0]   gdp_drop_count,
  output logic [31:0]   gdp_err_count
);

  localparam logic [1:0] IDLE_S = 2'd0;
  localparam logic [1:0] SEND_S = 2'd1;
  localparam logic [1:0] DROP_S = 2'd2;

  localparam logic [1:0] TUSER_TAIL = 2'b10;

  logic [1:0]   state_q, state_d;
  logic [7:0]   beat_cnt_q, beat_cnt_d;
  logic [255:0] md_q, md_d;
  logic         md_vld_q, md_vld_d;
  logic [767:0] phv_q, phv_d;
  logic         phv_vld_q, phv_vld_d;

  logic [255:0] data_q, data_d;
  logic         data_wr_q, data_wr_d;
  logic [1:0]   tuser_q, tuser_d;
  logic [31:0]  tkeep_q, tkeep_d;
  logic         valid_wr_q, valid_wr_d;
  logic         valid_q, valid_d;
  logic [31:0]  drop_cnt_q, drop_cnt_d;
  logic [31:0]  err_cnt_q, err_cnt_d;

  logic         ready_s;
  logic         accept_s;
  logic         release_s;
  logic         md_lost_s;
  logic         phv_lost_s;
  logic [32:0]  err_sum_s;
  logic [32:0]  drop_sum_s;
  logic [255:0] beat_sel_s;
  logic         unused_s;

  // PHV[1023:768] mirrors MD and MD[95:88] is overwritten by LMID, so neither is kept.
  assign unused_s = ^{in_gdp_phv[1023:768], md_q[95:88]};

  // Ready depends on the state and, while sending, on downstream back-pressure.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      IDLE_S:  ready_s = 1'b0;
      SEND_S:  ready_s = ~in_pktout_alf;
      DROP_S:  ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s  = in_gdp_data_valid & ready_s;
  // A tail accepted in IDLE_S is impossible (ready=0), so any accepted tail ends a packet.
  assign release_s = accept_s & (in_gdp_axis_tuser == TUSER_TAIL);

  // Holding registers: a write loads only into a free slot, or a slot being released this cycle.
  always_comb begin
    md_d       = md_q;
    md_vld_d   = md_vld_q;
    phv_d      = phv_q;
    phv_vld_d  = phv_vld_q;
    md_lost_s  = 1'b0;
    phv_lost_s = 1'b0;
    if (release_s) begin
      md_vld_d  = 1'b0;
      phv_vld_d = 1'b0;
    end else begin
      md_vld_d  = md_vld_q;
      phv_vld_d = phv_vld_q;
    end
    if (in_gdp_md_wr) begin
      if (!md_vld_q || release_s) begin
        md_d     = in_gdp_md;
        md_vld_d = 1'b1;
      end else begin
        md_lost_s = 1'b1;
      end
    end else begin
      md_lost_s = 1'b0;
    end
    if (in_gdp_phv_wr) begin
      if (!phv_vld_q || release_s) begin
        phv_d     = in_gdp_phv[767:0];
        phv_vld_d = 1'b1;
      end else begin
        phv_lost_s = 1'b1;
      end
    end else begin
      phv_lost_s = 1'b0;
    end
  end

  // Lost-write counter; MD and PHV may both be lost in one cycle.
  always_comb begin
    err_sum_s = {1'b0, err_cnt_q} + {32'd0, md_lost_s} + {32'd0, phv_lost_s};
    if (err_sum_s[32]) begin
      err_cnt_d = 32'hFFFF_FFFF;
    end else begin
      err_cnt_d = err_sum_s[31:0];
    end
  end

  // Output beat content chosen by position within the packet.
  always_comb begin
    beat_sel_s = in_gdp_data;
    case (beat_cnt_q)
      8'd0:    beat_sel_s = {md_q[255:96], LMID, md_q[87:0]};
      8'd1:    beat_sel_s = phv_q[767:512];
      8'd2:    beat_sel_s = phv_q[511:256];
      8'd3:    beat_sel_s = phv_q[255:0];
      default: beat_sel_s = in_gdp_data;
    endcase
  end

  assign drop_sum_s = {1'b0, drop_cnt_q} + 33'd1;

  // Packet state machine and next value of the registered output beat.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    tuser_d    = tuser_q;
    tkeep_d    = tkeep_q;
    valid_wr_d = 1'b0;
    valid_d    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE_S: begin
        if (md_vld_q && phv_vld_q) begin
          beat_cnt_d = 8'd0;
          state_d    = md_q[127] ? DROP_S : SEND_S;
        end else begin
          state_d = IDLE_S;
        end
      end
      SEND_S: begin
        if (accept_s) begin
          data_d     = beat_sel_s;
          data_wr_d  = 1'b1;
          tuser_d    = in_gdp_axis_tuser;
          tkeep_d    = in_gdp_axis_tkeep;
          beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
          if (release_s) begin
            valid_wr_d = 1'b1;
            valid_d    = 1'b1;
            state_d    = IDLE_S;
          end else begin
            state_d = SEND_S;
          end
        end else begin
          state_d = SEND_S;
        end
      end
      DROP_S: begin
        if (release_s) begin
          drop_cnt_d = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
          state_d    = IDLE_S;
        end else begin
          state_d = DROP_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State, holding and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_S;
      beat_cnt_q <= 8'd0;
      md_q       <= 256'd0;
      md_vld_q   <= 1'b0;
      phv_q      <= 768'd0;
      phv_vld_q  <= 1'b0;
      data_q     <= 256'd0;
      data_wr_q  <= 1'b0;
      tuser_q    <= 2'd0;
      tkeep_q    <= 32'd0;
      valid_wr_q <= 1'b0;
      valid_q    <= 1'b0;
      drop_cnt_q <= 32'd0;
      err_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      md_q       <= md_d;
      md_vld_q   <= md_vld_d;
      phv_q      <= phv_d;
      phv_vld_q  <= phv_vld_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      tuser_q    <= tuser_d;
      tkeep_q    <= tkeep_d;
      valid_wr_q <= valid_wr_d;
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_gdp_md_alf     = md_vld_q;
  assign out_gdp_phv_alf    = phv_vld_q;
  assign out_gdp_data_ready = ready_s;
  assign pktout_data        = data_q;
  assign pktout_data_wr     = data_wr_q;
  assign pktout_axis_tuser  = tuser_q;
  assign pktout_axis_tkeep  = tkeep_q;
  assign pktout_valid_wr    = valid_wr_q;
  assign pktout_valid       = valid_q;
  assign gdp_drop_count     = drop_cnt_q;
  assign gdp_err_count      = err_cnt_q;

endmodule

// File: tb/tb_gdp.sv
module tb_gdp;
  localparam logic [7:0] LMID = 8'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [255:0]  in_gdp_md = '0;
  logic          in_gdp_md_wr = 1'b0;
  logic          out_gdp_md_alf;
  logic [1023:0] in_gdp_phv = '0;
  logic          in_gdp_phv_wr = 1'b0;
  logic          out_gdp_phv_alf;
  logic [255:0]  in_gdp_data = '0;
  logic          in_gdp_data_valid = 1'b0;
  logic [1:0]    in_gdp_axis_tuser = '0;
  logic [31:0]   in_gdp_axis_tkeep = '0;
  logic          out_gdp_data_ready;
  logic [255:0]  pktout_data;
  logic          pktout_data_wr;
  logic [1:0]    pktout_axis_tuser;
  logic [31:0]   pktout_axis_tkeep;
  logic          pktout_valid_wr;
  logic          pktout_valid;
  logic          in_pktout_alf = 1'b0;
  logic [31:0]   gdp_drop_count;
  logic [31:0]   gdp_err_count;

  always #5 clk = ~clk;

  gdp #(.PLATFORM("Xilinx"), .LMID(LMID)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_gdp_md(in_gdp_md), .in_gdp_md_wr(in_gdp_md_wr), .out_gdp_md_alf(out_gdp_md_alf),
    .in_gdp_phv(in_gdp_phv), .in_gdp_phv_wr(in_gdp_phv_wr), .out_gdp_phv_alf(out_gdp_phv_alf),
    .in_gdp_data(in_gdp_data), .in_gdp_data_valid(in_gdp_data_valid),
    .in_gdp_axis_tuser(in_gdp_axis_tuser), .in_gdp_axis_tkeep(in_gdp_axis_tkeep),
    .out_gdp_data_ready(out_gdp_data_ready),
    .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr),
    .pktout_axis_tuser(pktout_axis_tuser), .pktout_axis_tkeep(pktout_axis_tkeep),
    .pktout_valid_wr(pktout_valid_wr), .pktout_valid(pktout_valid),
    .in_pktout_alf(in_pktout_alf),
    .gdp_drop_count(gdp_drop_count), .gdp_err_count(gdp_err_count)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   tuser;
    logic [31:0]  tkeep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: beat i of the emitted packet
  function automatic logic [255:0] ref_beat(input logic [255:0] md, input logic [1023:0] phv,
                                            input int idx, input logic [255:0] din);
    logic [255:0] r;
    if (idx == 0) begin
      r = md;
      r[95:88] = LMID;
    end else if (idx <= 3) begin
      r = phv[(1023 - 256*idx) -: 256];
    end else begin
      r = din;
    end
    return r;
  endfunction

  // Monitor: every output beat must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && pktout_data_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data %0h, required no beat", pktout_data);
      end else begin
        e = exp_q.pop_front();
        if ({pktout_data, pktout_axis_tuser, pktout_axis_tkeep, pktout_valid_wr, pktout_valid}
            !== {e.data, e.tuser, e.tkeep, e.last, e.last}) begin
          errors++;
          $display("FAIL out_beat: got %0h/%0h/%0h/%0b%0b, required %0h/%0h/%0h/%0b%0b",
                   pktout_data, pktout_axis_tuser, pktout_axis_tkeep, pktout_valid_wr, pktout_valid,
                   e.data, e.tuser, e.tkeep, e.last, e.last);
        end
      end
    end
  end

  task automatic write_md(input logic [255:0] md);
    @(negedge clk);
    in_gdp_md = md;
    in_gdp_md_wr = 1'b1;
    @(negedge clk);
    in_gdp_md_wr = 1'b0;
    #1;
    check("md_alf_set", {255'd0, out_gdp_md_alf}, 256'd1);
  endtask

  task automatic write_phv(input logic [1023:0] phv);
    @(negedge clk);
    in_gdp_phv = phv;
    in_gdp_phv_wr = 1'b1;
    @(negedge clk);
    in_gdp_phv_wr = 1'b0;
    #1;
    check("phv_alf_set", {255'd0, out_gdp_phv_alf}, 256'd1);
  endtask

  // alf_mode: 0 none, 1 toggle each cycle, 2 random. mid_md_beat: beat at which a
  // second MD is written (-1 none). md_on_tail: write md2 with the tail beat.
  // abort_at: pulse reset instead of driving that beat (-1 none).
  task automatic send_pkt(input int n, input logic [255:0] md, input logic [1023:0] phv,
                          input logic [31:0] tail_keep, input int alf_mode,
                          input int mid_md_beat, input bit md_on_tail,
                          input logic [255:0] md2, input int abort_at);
    logic [255:0] dq[$];
    logic [31:0]  kq[$];
    logic [1:0]   uq[$];
    bit drop = md[127];
    int cyc = 0;
    int limit = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < n; i++) begin
      dq.push_back(rand256());
      kq.push_back((i == n-1) ? tail_keep : $urandom);
      uq.push_back((i == 0) ? 2'b01 : ((i == n-1) ? 2'b10 : 2'b00));
    end
    if (!drop) begin
      for (int i = 0; i < limit; i++)
        exp_q.push_back('{ref_beat(md, phv, i, dq[i]), uq[i], kq[i], i == n-1});
    end
    for (int b = 0; b < n; b++) begin
      bit acc = 1'b0;
      int waited = 0;
      while (!acc) begin
        @(negedge clk);
        if (b == abort_at) begin
          #2;
          rst_n = 1'b0;
          in_gdp_data_valid = 1'b0;
          in_pktout_alf = 1'b0;
          exp_drop = 0;
          exp_err = 0;
          #1;
          check("rst_mid_data", pktout_data, 256'd0);
          check("rst_mid_ctrl", {152'd0, pktout_data_wr, pktout_axis_tuser, pktout_axis_tkeep,
                pktout_valid_wr, pktout_valid, gdp_drop_count, gdp_err_count,
                out_gdp_data_ready, out_gdp_md_alf, out_gdp_phv_alf}, 256'd0);
          check("rst_mid_sb_empty", 256'(exp_q.size()), 256'd0);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        cyc++;
        case (alf_mode)
          1:       in_pktout_alf = cyc[0];
          2:       in_pktout_alf = ($urandom_range(0, 2) == 0);
          default: in_pktout_alf = 1'b0;
        endcase
        in_gdp_data = dq[b];
        in_gdp_axis_tuser = uq[b];
        in_gdp_axis_tkeep = kq[b];
        in_gdp_data_valid = 1'b1;
        in_gdp_md_wr = (waited == 0) && ((b == mid_md_beat) || (md_on_tail && b == n-1));
        if (in_gdp_md_wr) in_gdp_md = md2;
        if (b == mid_md_beat && waited == 0) exp_err++;
        #1;
        if (b > 0 && !drop)
          check("ready_tracks_alf", {255'd0, out_gdp_data_ready}, {255'd0, ~in_pktout_alf});
        if (b == n-1 && waited == 0)
          check("md_alf_before_tail", {255'd0, out_gdp_md_alf}, 256'd1);
        acc = out_gdp_data_ready;
        waited++;
        if (!acc && waited > 200) begin
          errors++;
          checks++;
          $display("FAIL accept_timeout: got no accept at beat %0d, required accept", b);
          in_gdp_data_valid = 1'b0;
          in_gdp_md_wr = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_gdp_data_valid = 1'b0;
    in_gdp_md_wr = 1'b0;
    in_pktout_alf = 1'b0;
    if (drop) exp_drop++;
    #1;
    check("md_alf_after_tail", {255'd0, out_gdp_md_alf}, {255'd0, md_on_tail});
    check("phv_alf_after_tail", {255'd0, out_gdp_phv_alf}, 256'd0);
    check("drop_count", {224'd0, gdp_drop_count}, 256'(exp_drop));
  endtask

  initial begin : stim
    logic [255:0]  md, md_b;
    logic [1023:0] phv;
    // Reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_data", pktout_data, 256'd0);
    check("rst_ctrl", {152'd0, pktout_data_wr, pktout_axis_tuser, pktout_axis_tkeep,
          pktout_valid_wr, pktout_valid, gdp_drop_count, gdp_err_count,
          out_gdp_data_ready, out_gdp_md_alf, out_gdp_phv_alf}, 256'd0);
    rst_n = 1'b1;

    // 6-beat packet, MD[95:88]=0 so the LMID stamp is visible
    md = rand256(); md[127] = 1'b0; md[95:88] = 8'h00;
    phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(6, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, -1);

    // 2-beat packet with a half tkeep on the tail
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(2, md, phv, 32'h0000_FFFF, 0, -1, 1'b0, '0, -1);

    // Dropped 5-beat packet, then a normal one
    md = rand256(); md[127] = 1'b1; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(5, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, -1);
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(4, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, -1);

    // 10-beat packet with alf toggling
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(10, md, phv, 32'h0000_00FF, 1, -1, 1'b0, '0, -1);

    // Second MD mid-packet is lost; MD on the tail cycle is kept
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    md_b = rand256(); md_b[127] = 1'b0;
    write_md(md); write_phv(phv);
    send_pkt(5, md, phv, 32'hFFFF_FFFF, 0, 2, 1'b1, md_b, -1);
    check("err_count", {224'd0, gdp_err_count}, 256'(exp_err));
    phv = rand1024();
    write_phv(phv);
    send_pkt(3, md_b, phv, 32'h0000_000F, 0, -1, 1'b0, '0, -1);
    check("err_count_hold", {224'd0, gdp_err_count}, 256'(exp_err));

    // Reset pulsed during beat 3 of 8, then a clean packet
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(8, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, 3);
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(7, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, -1);

    // Randomized packets under random back-pressure
    for (int p = 0; p < 10; p++) begin
      md = rand256(); md[127] = ($urandom_range(0, 3) == 0); phv = rand1024();
      write_md(md); write_phv(phv);
      send_pkt($urandom_range(2, 12), md, phv, $urandom, 2, -1, 1'b0, '0, -1);
    end

    // Long packet past the beat-counter saturation point
    md = rand256(); md[127] = 1'b0; phv = rand1024();
    write_md(md); write_phv(phv);
    send_pkt(260, md, phv, 32'hFFFF_FFFF, 0, -1, 1'b0, '0, -1);

    repeat (5) @(negedge clk);
    #1;
    check("sb_empty", 256'(exp_q.size()), 256'd0);
    check("final_drop_count", {224'd0, gdp_drop_count}, 256'(exp_drop));
    check("final_err_count", {224'd0, gdp_err_count}, 256'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
